// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler
//   Round-robin / fixed-priority arbiter that shares one downstream resource
//   among up to N requesters. A grant is registered, held until the owner
//   pulses owner_release or the watchdog revokes it, and is always followed
//   by a one-cycle idle bubble before the next grant.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   req[N]         request vector, bit i = requester i wants the resource
//   enable         0 blocks new grants (a held grant is unaffected)
//   rr_mode        1 = descending round-robin, 0 = fixed priority (highest index)
//   owner_release  pulse from the current owner: resource done
//   grant_valid    a grant is held
//   grant_idx      index of the owner, valid when grant_valid
//   grant_onehot   one-hot of grant_idx, all zero when !grant_valid
//   timeout_pulse  one-cycle pulse when the watchdog revokes a grant
//   last_idx       round-robin pointer (last serviced index)

module rr_grant_scheduler #(
  parameter int N       = 256,
  parameter int IDX_W   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             enable,
  input  logic             rr_mode,
  input  logic             owner_release,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant_onehot,
  output logic             timeout_pulse,
  output logic [IDX_W-1:0] last_idx
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A TIMEOUT of zero turns the watchdog off entirely.
  localparam bit             WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  // Highest set index of a vector (higher index wins); zero for an empty vector.
  function automatic logic [IDX_W-1:0] highest_idx(input logic [N-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             grant_valid_r;
  logic             grant_valid_nxt_s;
  logic [IDX_W-1:0] grant_idx_r;
  logic [IDX_W-1:0] grant_idx_nxt_s;
  logic [N-1:0]     grant_onehot_r;
  logic [N-1:0]     grant_onehot_nxt_s;
  logic             timeout_pulse_r;
  logic             timeout_pulse_nxt_s;
  logic [IDX_W-1:0] last_idx_r;
  logic [IDX_W-1:0] last_idx_nxt_s;
  logic [CNT_W-1:0] watchdog_r;
  logic [CNT_W-1:0] watchdog_nxt_s;

  logic [N-1:0]     low_mask_s;
  logic [N-1:0]     masked_req_s;
  logic [IDX_W-1:0] sel_idx_s;
  logic             req_any_s;
  logic             wd_expire_s;
  logic [N-1:0]     one_s;

  assign one_s       = {{(N-1){1'b0}}, 1'b1};
  assign req_any_s   = (req != {N{1'b0}});
  assign wd_expire_s = WD_EN && (watchdog_r == WD_LAST);

  // Requests strictly below the round-robin pointer; searching these first
  // and falling back to the full vector gives a descending rotation.
  always_comb begin
    low_mask_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      low_mask_s[i] = (IDX_W'(i) < last_idx_r);
    end
    masked_req_s = req & low_mask_s;
  end

  // Winner selection: rotated search in round-robin mode, plain highest index otherwise.
  always_comb begin
    if (rr_mode && (masked_req_s != {N{1'b0}})) begin
      sel_idx_s = highest_idx(masked_req_s);
    end else begin
      sel_idx_s = highest_idx(req);
    end
  end

  // State and registered outputs; reset drops any held grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      grant_valid_r   <= 1'b0;
      grant_idx_r     <= {IDX_W{1'b0}};
      grant_onehot_r  <= {N{1'b0}};
      timeout_pulse_r <= 1'b0;
      last_idx_r      <= {IDX_W{1'b0}};
      watchdog_r      <= {CNT_W{1'b0}};
    end else begin
      state_r         <= state_nxt_s;
      grant_valid_r   <= grant_valid_nxt_s;
      grant_idx_r     <= grant_idx_nxt_s;
      grant_onehot_r  <= grant_onehot_nxt_s;
      timeout_pulse_r <= timeout_pulse_nxt_s;
      last_idx_r      <= last_idx_nxt_s;
      watchdog_r      <= watchdog_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable && req_any_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (owner_release || wd_expire_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and the watchdog.
  always_comb begin
    grant_valid_nxt_s   = 1'b0;
    grant_idx_nxt_s     = {IDX_W{1'b0}};
    grant_onehot_nxt_s  = {N{1'b0}};
    timeout_pulse_nxt_s = 1'b0;
    last_idx_nxt_s      = last_idx_r;
    watchdog_nxt_s      = {CNT_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (enable && req_any_s) begin
          grant_valid_nxt_s  = 1'b1;
          grant_idx_nxt_s    = sel_idx_s;
          grant_onehot_nxt_s = one_s << sel_idx_s;
        end else begin
          grant_valid_nxt_s  = 1'b0;
        end
      end
      GRANT: begin
        if (owner_release) begin
          // Release has priority over a coinciding watchdog expiry.
          last_idx_nxt_s      = grant_idx_r;
        end else if (wd_expire_s) begin
          timeout_pulse_nxt_s = 1'b1;
          last_idx_nxt_s      = grant_idx_r;
        end else begin
          grant_valid_nxt_s   = 1'b1;
          grant_idx_nxt_s     = grant_idx_r;
          grant_onehot_nxt_s  = grant_onehot_r;
          watchdog_nxt_s      = watchdog_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        grant_valid_nxt_s = 1'b0;
      end
    endcase
  end

  assign grant_valid   = grant_valid_r;
  assign grant_idx     = grant_idx_r;
  assign grant_onehot  = grant_onehot_r;
  assign timeout_pulse = timeout_pulse_r;
  assign last_idx      = last_idx_r;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
module tb_rr_grant_scheduler;

  localparam int N       = 256;
  localparam int IDX_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic             enable;
  logic             rr_mode;
  logic             owner_release;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [N-1:0]     grant_onehot;
  logic             timeout_pulse;
  logic [IDX_W-1:0] last_idx;

  int vectors;
  int miscompares;

  rr_grant_scheduler #(
    .N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .enable(enable), .rr_mode(rr_mode),
    .owner_release(owner_release), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .grant_onehot(grant_onehot), .timeout_pulse(timeout_pulse), .last_idx(last_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] bit_at(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req = '0; enable = 1'b0; rr_mode = 1'b1; owner_release = 1'b0;
    #3;
    vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", grant_valid); end
    vectors++; if (grant_idx !== 8'd0) begin miscompares++; $display("FAIL reset_idx got=%0d want=0", grant_idx); end
    vectors++; if (grant_onehot !== '0) begin miscompares++; $display("FAIL reset_onehot got=%h want=0", grant_onehot); end
    vectors++; if (timeout_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_pulse got=%b want=0", timeout_pulse); end
    vectors++; if (last_idx !== 8'd0) begin miscompares++; $display("FAIL reset_last got=%0d want=0", last_idx); end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset got=%b want=0", grant_valid); end
  endtask

  task automatic test_basic();
    req = bit_at(0); enable = 1'b1; rr_mode = 1'b1;
    tick();
    vectors++; if (grant_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%b want=1", grant_valid); end
    vectors++; if (grant_idx !== 8'd0) begin miscompares++; $display("FAIL basic_idx got=%0d want=0", grant_idx); end
    vectors++; if (grant_onehot !== bit_at(0)) begin miscompares++; $display("FAIL basic_onehot got=%h want=%h", grant_onehot, bit_at(0)); end
    owner_release = 1'b1; req = '0;
    tick();
    owner_release = 1'b0;
    vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL basic_release got=%b want=0", grant_valid); end
    vectors++; if (last_idx !== 8'd0) begin miscompares++; $display("FAIL basic_last got=%0d want=0", last_idx); end
    tick();
  endtask

  // Descending rotation 200 -> 100 -> 5 -> 200 with a bubble after each release.
  task automatic test_round_robin();
    int exp_seq [4] = '{200, 100, 5, 200};
    req = bit_at(200) | bit_at(100) | bit_at(5); rr_mode = 1'b1; enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (grant_valid !== 1'b1 || grant_idx !== IDX_W'(exp_seq[k])) begin miscompares++; $display("FAIL rr_grant%0d got=%b/%0d want=1/%0d", k, grant_valid, grant_idx, exp_seq[k]); end
      vectors++; if (grant_onehot !== bit_at(exp_seq[k])) begin miscompares++; $display("FAIL rr_onehot%0d got=%h want=%h", k, grant_onehot, bit_at(exp_seq[k])); end
      tick(); tick();
      vectors++; if (grant_valid !== 1'b1) begin miscompares++; $display("FAIL rr_hold%0d got=%b want=1", k, grant_valid); end
      owner_release = 1'b1;
      tick();
      owner_release = 1'b0;
      vectors++; if (grant_valid !== 1'b0 || grant_onehot !== '0) begin miscompares++; $display("FAIL rr_bubble%0d got=%b want=0", k, grant_valid); end
      vectors++; if (last_idx !== IDX_W'(exp_seq[k])) begin miscompares++; $display("FAIL rr_last%0d got=%0d want=%0d", k, last_idx, exp_seq[k]); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_fixed_priority();
    req = bit_at(200) | bit_at(100) | bit_at(5); rr_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (grant_valid !== 1'b1 || grant_idx !== 8'd200) begin miscompares++; $display("FAIL fixed%0d got=%b/%0d want=1/200", k, grant_valid, grant_idx); end
      owner_release = 1'b1;
      tick();
      owner_release = 1'b0;
    end
    req = '0; rr_mode = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int held;
    // last_idx is 200, so idx 7 is reached through the masked search.
    req = bit_at(7);
    tick();
    vectors++; if (grant_valid !== 1'b1 || grant_idx !== 8'd7) begin miscompares++; $display("FAIL to_grant got=%b/%0d want=1/7", grant_valid, grant_idx); end
    req = '0;
    held = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (grant_valid === 1'b1 && timeout_pulse === 1'b0) held++;
    end
    vectors++; if (held != 15) begin miscompares++; $display("FAIL to_hold got=%0d want=15 cycles", held); end
    tick();
    vectors++; if (grant_valid !== 1'b0 || timeout_pulse !== 1'b1) begin miscompares++; $display("FAIL to_revoke got=%b/%b want=0/1", grant_valid, timeout_pulse); end
    vectors++; if (last_idx !== 8'd7) begin miscompares++; $display("FAIL to_last got=%0d want=7", last_idx); end
    tick();
    vectors++; if (timeout_pulse !== 1'b0) begin miscompares++; $display("FAIL to_pulse_width got=%b want=0", timeout_pulse); end
    // Release in the final cycle beats the watchdog.
    req = bit_at(7);
    tick();
    req = '0;
    for (int k = 0; k < 15; k++) tick();
    vectors++; if (grant_valid !== 1'b1) begin miscompares++; $display("FAIL to_rel_hold got=%b want=1", grant_valid); end
    owner_release = 1'b1;
    tick();
    owner_release = 1'b0;
    vectors++; if (grant_valid !== 1'b0 || timeout_pulse !== 1'b0) begin miscompares++; $display("FAIL to_rel_wins got=%b/%b want=0/0", grant_valid, timeout_pulse); end
    tick();
    vectors++; if (timeout_pulse !== 1'b0) begin miscompares++; $display("FAIL to_rel_nopulse got=%b want=0", timeout_pulse); end
  endtask

  task automatic test_async_reset();
    req = bit_at(255);
    tick();
    vectors++; if (grant_valid !== 1'b1 || grant_idx !== 8'd255) begin miscompares++; $display("FAIL ar_grant got=%b/%0d want=1/255", grant_valid, grant_idx); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (grant_valid !== 1'b0 || grant_onehot !== '0) begin miscompares++; $display("FAIL ar_drop got=%b/%h want=0/0", grant_valid, grant_onehot); end
    vectors++; if (last_idx !== 8'd0) begin miscompares++; $display("FAIL ar_last got=%0d want=0", last_idx); end
    #1 rst_n = 1'b1;
    tick();
    vectors++; if (grant_valid !== 1'b1 || grant_idx !== 8'd255 || grant_onehot !== bit_at(255)) begin miscompares++; $display("FAIL ar_regrant got=%b/%0d want=1/255", grant_valid, grant_idx); end
    owner_release = 1'b1; req = '0;
    tick();
    owner_release = 1'b0;
    vectors++; if (last_idx !== 8'd255) begin miscompares++; $display("FAIL ar_rel_last got=%0d want=255", last_idx); end
  endtask

  task automatic test_enable();
    int idle_ok;
    enable = 1'b0; req = bit_at(100);
    idle_ok = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (grant_valid === 1'b0) idle_ok++;
    end
    vectors++; if (idle_ok != 10) begin miscompares++; $display("FAIL en_block got=%0d want=10 idle cycles", idle_ok); end
    enable = 1'b1;
    tick();
    vectors++; if (grant_valid !== 1'b1 || grant_idx !== 8'd100) begin miscompares++; $display("FAIL en_grant got=%b/%0d want=1/100", grant_valid, grant_idx); end
    // Owner drops its request and enable falls: the grant must stay.
    req = '0; enable = 1'b0;
    tick(); tick(); tick();
    vectors++; if (grant_valid !== 1'b1 || grant_idx !== 8'd100) begin miscompares++; $display("FAIL en_held got=%b/%0d want=1/100", grant_valid, grant_idx); end
    owner_release = 1'b1;
    tick();
    vectors++; if (grant_valid !== 1'b0 || last_idx !== 8'd100) begin miscompares++; $display("FAIL en_release got=%b/%0d want=0/100", grant_valid, last_idx); end
    // Release while idle does nothing.
    tick();
    owner_release = 1'b0;
    vectors++; if (grant_valid !== 1'b0 || timeout_pulse !== 1'b0 || last_idx !== 8'd100) begin miscompares++; $display("FAIL en_idle_release got=%b/%0d want=0/100", grant_valid, last_idx); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_async_reset();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
